tdm_demux: RTL
==============

# tdm_demux

Receive-side counterpart of the team's enabled 2:1 mux. It takes a serial time-division-multiplexed bit stream, built by muxing several channel words onto one wire, and demultiplexes it back into per-channel parallel registers. Frame alignment comes from a sync strobe. A slot/bit counter state machine steers each completed word to its channel register and raises a per-channel valid pulse. The block sits at the far end of a TDM link, directly after the serial wire, and feeds parallel consumers.

## Interface
- CHANNELS, 4: number of slots per frame (≥2)
- WIDTH, 8: bits per slot, MSB first (≥2)
- clk  in  1  single clock; all sampling on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  enable; when low, the block freezes (no sampling, no counting, no pulses)
- sync  in  1  frame-start strobe; asserted together with bit 0 (MSB) of slot 0
- sdata  in  1  serial data bit
- ch_data  out  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- ch_valid  out  CHANNELS  one-cycle pulse; bit i means ch_data for channel i was just updated
- frame_done  out  1  one-cycle pulse coincident with the last channel's ch_valid
- sync_err  out  1  one-cycle pulse when sync arrives in the middle of a frame

## Operation
- FSM states: IDLE, RECV.
- **IDLE:** wait for en & sync. On that edge:
  - shift sdata into the shift register;
  - set bit_cnt=1 and slot_cnt=0;
  - go to RECV.
- **RECV, edge with en=1 and sync=0:**
  - shift sdata in (MSB first) and increment bit_cnt.
  - On the edge sampling bit WIDTH-1 of a slot: load the full word into ch_data[slot_cnt], pulse ch_valid[slot_cnt], clear bit_cnt, increment slot_cnt.
  - On the last bit of slot CHANNELS-1: also pulse frame_done and return to IDLE.
- **RECV, edge with en=1 and sync=1 (mid-frame resync):**
  - discard the partial word; ch_data is not updated;
  - pulse sync_err;
  - restart as if from IDLE: the sampled bit becomes bit 0 of slot 0; stay in RECV.
- **Back-to-back frames:** sync on the edge immediately after the last bit of a frame is a normal start. It is accepted from IDLE with no gap and no sync_err.
- **en=0 in any state:** state, counters, shift register and ch_data hold; sync and sdata are ignored; all pulse outputs are 0.
- ch_data for a channel holds its last word until the same slot completes again.
- Counter widths: $clog2(WIDTH) for bit_cnt, $clog2(CHANNELS) for slot_cnt. Counters never wrap silently; the terminal count drives the transition.

## Timing
- **Reset values:** state=IDLE, counters 0, shift register 0, ch_data all 0, ch_valid 0, frame_done 0, sync_err 0.
- **Reset mid-frame:** immediate return to the reset values; the partial frame is lost.
- **Latency:** ch_data[i] and ch_valid[i] are visible in the cycle after the edge that sampled the slot's LSB.
- **Frame length:** CHANNELS*WIDTH enabled cycles (32 at defaults). frame_done falls in the cycle after the 32nd sampled bit.
- All outputs are registered. Pulses last exactly one clk cycle.
- At most one ch_valid bit is high in any cycle. sync_err and ch_valid are never high together.

## Structure
- A shared include, tdm_defs.vh, holds:
  - state encodings (IDLE, RECV);
  - default CHANNELS/WIDTH;
  - the slot-index helper macro.
- The TDM transmitter uses the same include.
- One sub-module, tdm_shift_in: a WIDTH-bit MSB-first shift register with enable and a word-complete flag.
- The FSM, counters and channel register bank stay in the top module.

## Test plan
- **Reset, then idle:** rst=1 then 0 with en=1 and sync=0 for 40 cycles → all outputs 0, ch_data=0.
- **Full frame:** with defaults, send 0xA5, 0x3C, 0xFF, 0x01 after sync → ch_valid pulses 0001, 0010, 0100, 1000 at cycles 9, 17, 25, 33 after the sync edge; frame_done at cycle 33; ch_data=0x01FF3CA5.
- **Back-to-back frames:** second frame 0x11, 0x22, 0x33, 0x44 with sync right after bit 32 → no sync_err; ch_data=0x44332211.
- **Mid-frame resync:** sync again at bit 12 of the frame → sync_err pulse; channel 1 is not updated; the new frame completes correctly from the resync point.
- **Enable gating:** drop en for 5 cycles in the middle of slot 2 (sdata and sync toggling meanwhile) → the received words are identical to the ungated run; every pulse is delayed by exactly 5 cycles.
- **Reset mid-frame:** assert rst during slot 3 → all outputs 0 immediately; the next synced frame decodes normally.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: FSM state type, default frame
// geometry and the slot-to-bit-offset helper used by both link ends.
package tdm_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_WIDTH    = 8;

    // Bit offset of a slot's word inside the packed channel bus.
    function automatic int unsigned slot_lsb(input int unsigned slot,
                                             input int unsigned width);
        return slot * width;
    endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// MSB-first serial-to-parallel word assembler. Only WIDTH-1 bits are stored;
// the bit being sampled completes the word, so the full word is available
// combinationally on the edge that samples the slot's LSB.
module tdm_shift_in
    import tdm_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_i,
    input  logic             restart_i,
    input  logic             last_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o,
    output logic             done_o
);

    localparam int unsigned HW = WIDTH - 1;

    logic [HW-1:0] sh_q;
    logic [HW-1:0] sh_d;

    assign word_o = {sh_q, bit_i};
    // A restart discards the partial word, so it never completes one.
    assign done_o = shift_i & last_i & ~restart_i;

    // Next shift contents: restart seeds bit 0 of a fresh word.
    always_comb begin
        sh_d = sh_q;
        if (shift_i) begin
            sh_d = restart_i ? HW'(bit_i) : word_o[HW-1:0];
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: aligns on the sync strobe, counts bits and slots, and steers
// each completed word into its channel register with a one-cycle valid pulse.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      sdata,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      sync_err
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned SW = $clog2(CHANNELS);

    state_e                    state_q, state_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]             slot_cnt_q, slot_cnt_d;
    logic [CHANNELS*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [CHANNELS-1:0]       ch_valid_q, ch_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;

    logic                      shift;
    logic                      last_bit;
    logic                      last_slot;
    logic                      word_done;
    logic [WIDTH-1:0]          word;

    // Shift/restart decisions are kept outside the FSM block so the
    // word-complete flag coming back from the shifter forms no comb loop.
    assign shift     = en & ((state_q == RECV) | sync);
    assign last_bit  = (bit_cnt_q == BW'(WIDTH - 1));
    assign last_slot = (slot_cnt_q == SW'(CHANNELS - 1));

    tdm_shift_in #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .shift_i   (shift),
        .restart_i (sync),
        .last_i    (last_bit),
        .bit_i     (sdata),
        .word_o    (word),
        .done_o    (word_done)
    );

    // Next-state, counters, channel bank and pulse generation.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (en) begin
            if (sync) begin
                // Frame start from IDLE, or resync from RECV.
                sync_err_d = (state_q == RECV);
                bit_cnt_d  = BW'(1);
                slot_cnt_d = '0;
                state_d    = RECV;
            end else if (state_q == RECV) begin
                if (word_done) begin
                    ch_data_d[slot_lsb(32'(slot_cnt_q), WIDTH) +: WIDTH] = word;
                    ch_valid_d[slot_cnt_q] = 1'b1;
                    bit_cnt_d = '0;
                    if (last_slot) begin
                        frame_done_d = 1'b1;
                        slot_cnt_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule
